// File: rtl/key_step_conditioner.sv
// rtl/key_step_conditioner.sv - debounced push-button to single-cycle step pulse with synced switch capture
// Optional auto-repeat while held: define AUTO_REPEAT_EN.
module key_step_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  input  logic sw_in,
  output logic step,
  output logic pressed,
  output logic sw_level
);

  localparam logic [CNT_W-1:0] LP_DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_HELD,
    ST_RELEASE_WAIT
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_key_m, r_key_s;
  logic             r_sw_m, r_sw_s;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_step, w_step_nxt;
  logic             r_pressed, w_pressed_nxt;
  logic             r_sw_level, w_sw_level_nxt;

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] LP_RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] r_rcnt, w_rcnt_nxt;
`else
  logic w_unused_rpt;
  assign w_unused_rpt = (REPEAT_CYCLES > 0);
`endif

  // Synchronizers: key idles released (1), switch idles low.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key_m <= 1'b1;
      r_key_s <= 1'b1;
      r_sw_m  <= 1'b0;
      r_sw_s  <= 1'b0;
    end else begin
      r_key_m <= key_n;
      r_key_s <= r_key_m;
      r_sw_m  <= sw_in;
      r_sw_s  <= r_sw_m;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_step_nxt     = 1'b0;
    w_pressed_nxt  = r_pressed;
    w_sw_level_nxt = r_sw_level;
`ifdef AUTO_REPEAT_EN
    w_rcnt_nxt     = r_rcnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!r_key_s) begin
          w_state_nxt = ST_PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (r_key_s) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LP_DB_LAST) begin
          w_state_nxt    = ST_HELD;
          w_cnt_nxt      = '0;
          w_step_nxt     = 1'b1;
          w_pressed_nxt  = 1'b1;
          w_sw_level_nxt = r_sw_s;
`ifdef AUTO_REPEAT_EN
          w_rcnt_nxt     = '0;
`endif
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (r_key_s) begin
          w_state_nxt = ST_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
`ifdef AUTO_REPEAT_EN
        else if (r_rcnt == LP_RPT_LAST) begin
          w_step_nxt     = 1'b1;
          w_sw_level_nxt = r_sw_s;
          w_rcnt_nxt     = '0;
        end else begin
          w_rcnt_nxt = r_rcnt + CNT_W'(1);
        end
`endif
      end
      ST_RELEASE_WAIT: begin
        // A bounce back to low resumes the hold without a new step.
        if (!r_key_s) begin
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = '0;
`ifdef AUTO_REPEAT_EN
          w_rcnt_nxt  = '0;
`endif
        end else if (r_cnt == LP_DB_LAST) begin
          w_state_nxt   = ST_IDLE;
          w_cnt_nxt     = '0;
          w_pressed_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_step     <= 1'b0;
      r_pressed  <= 1'b0;
      r_sw_level <= 1'b0;
`ifdef AUTO_REPEAT_EN
      r_rcnt     <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_step     <= w_step_nxt;
      r_pressed  <= w_pressed_nxt;
      r_sw_level <= w_sw_level_nxt;
`ifdef AUTO_REPEAT_EN
      r_rcnt     <= w_rcnt_nxt;
`endif
    end
  end

  assign step     = r_step;
  assign pressed  = r_pressed;
  assign sw_level = r_sw_level;

endmodule

// File: tb/tb_key_step_conditioner.sv
// tb/tb_key_step_conditioner.sv - directed-vector bench for key_step_conditioner (DEBOUNCE=4, CNT_W=8, REPEAT=8)
// Expectations follow AUTO_REPEAT_EN when it is defined.
module tb_key_step_conditioner;

`ifdef AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk;
  logic reset;
  logic key_n;
  logic sw_in;
  logic step;
  logic pressed;
  logic sw_level;

  int n_vec = 0;
  int n_err = 0;

  key_step_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(8),
    .REPEAT_CYCLES(8)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .key_n(key_n),
    .sw_in(sw_in),
    .step(step),
    .pressed(pressed),
    .sw_level(sw_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    key_n = 1'b1;
    sw_in = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int nsteps;
    reset = 1'b1;
    key_n = 1'b1;
    sw_in = 1'b0;

    // Reset state
    do_reset();
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_pressed", 32'(pressed), 32'd0);
    chk("rst_sw_level", 32'(sw_level), 32'd0);

    // 1. Clean press for 20 edges, then release
    for (int e = 0; e < 30; e++) begin
      key_n = (e < 20) ? 1'b0 : 1'b1;
      tick();
      chk($sformatf("t1_step@%0d", e), 32'(step), 32'(e == 6 || (AR && e == 14)));
      chk($sformatf("t1_pressed@%0d", e), 32'(pressed), 32'(e >= 6 && e < 26));
    end

    // 2. Press bounce: low for 3 edges only
    do_reset();
    for (int e = 0; e < 13; e++) begin
      key_n = (e < 3) ? 1'b0 : 1'b1;
      tick();
      chk($sformatf("t2_step@%0d", e), 32'(step), 32'd0);
      chk($sformatf("t2_pressed@%0d", e), 32'(pressed), 32'd0);
    end

    // 3. Release bounce: 2 high edges while held, then clean release from edge 20
    do_reset();
    for (int e = 0; e < 30; e++) begin
      key_n = (e < 10) ? 1'b0 : (e < 12) ? 1'b1 : (e < 20) ? 1'b0 : 1'b1;
      tick();
      chk($sformatf("t3_step@%0d", e), 32'(step), 32'(e == 6));
      chk($sformatf("t3_pressed@%0d", e), 32'(pressed), 32'(e >= 6 && e < 26));
    end

    // 4. Switch capture across two presses
    do_reset();
    for (int e = 0; e < 32; e++) begin
      sw_in = (e < 8) ? 1'b1 : 1'b0;
      key_n = (e < 12) ? 1'b0 : (e < 22) ? 1'b1 : 1'b0;
      tick();
      chk($sformatf("t4_step@%0d", e), 32'(step), 32'(e == 6 || e == 28));
      chk($sformatf("t4_sw_level@%0d", e), 32'(sw_level), 32'(e >= 6 && e < 28));
      chk($sformatf("t4_pressed@%0d", e), 32'(pressed), 32'((e >= 6 && e < 18) || e >= 28));
    end

    // 5. Reset for one edge mid-debounce
    do_reset();
    for (int e = 0; e < 16; e++) begin
      key_n = 1'b0;
      sw_in = 1'b1;
      reset = (e == 4);
      tick();
      chk($sformatf("t5_step@%0d", e), 32'(step), 32'(e == 11));
      chk($sformatf("t5_pressed@%0d", e), 32'(pressed), 32'(e >= 11));
      chk($sformatf("t5_sw_level@%0d", e), 32'(sw_level), 32'(e >= 11));
    end
    reset = 1'b0;

    // 6. Long hold for 32 edges
    do_reset();
    nsteps = 0;
    for (int e = 0; e < 40; e++) begin
      key_n = (e < 32) ? 1'b0 : 1'b1;
      tick();
      if (step) nsteps++;
      chk($sformatf("t6_step@%0d", e), 32'(step),
          32'(e == 6 || (AR && (e == 14 || e == 22 || e == 30))));
      chk($sformatf("t6_pressed@%0d", e), 32'(pressed), 32'(e >= 6 && e < 38));
    end
    chk("t6_step_count", 32'(nsteps), AR ? 32'd4 : 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
